// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer.
// The optional stall counter in fetch_seq is enabled by defining FETCH_STALL_CNT_EN.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 17;
  localparam int unsigned LAT_CNT_W  = 3;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StHold,
    StInc,
    StJump,
    StClear
  } fetch_state_e;

endpackage

// File: rtl/fetch_lat_cnt.sv
// Loadable down-counter for fixed-latency memory reads.
// done_o marks the final wait cycle, i.e. the cycle in which read data is valid.
module fetch_lat_cnt
  import fetch_pkg::*;
#(
  parameter int unsigned CntW = LAT_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: reads instruction memory at the PC, holds the word for the decoder,
// then steps or loads the PC. Define FETCH_STALL_CNT_EN to add the stall_cnt output.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              restart,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_write_en,
  output logic              pc_inc_en,
  output logic              pc_clr_en,
  output logic [DATA_W-1:0] pc_datain,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_target,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              busy
);

  fetch_state_e      state_q;
  logic              halt_q;
  logic              pc_write_en_q, pc_inc_en_q, pc_clr_en_q, mem_rd_en_q, ir_valid_q;
  logic [DATA_W-1:0] pc_datain_q, ir_out_q;
  logic              lat_done;

  fetch_lat_cnt #(
    .CntW (LAT_CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (restart),
    .load_i     (state_q == StIssue),
    .load_val_i (LAT_CNT_W'(MEM_LAT)),
    .dec_i      (state_q == StWait),
    .done_o     (lat_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      halt_q        <= 1'b0;
      pc_write_en_q <= 1'b0;
      pc_inc_en_q   <= 1'b0;
      pc_clr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      ir_valid_q    <= 1'b0;
      pc_datain_q   <= '0;
      ir_out_q      <= '0;
    end else begin
      // Strobes are one-cycle pulses unless re-armed below.
      pc_write_en_q <= 1'b0;
      pc_inc_en_q   <= 1'b0;
      pc_clr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      pc_datain_q   <= '0;
      if (restart) begin
        state_q     <= StClear;
        pc_clr_en_q <= 1'b1;
        ir_valid_q  <= 1'b0;
        halt_q      <= 1'b0;
      end else begin
        halt_q <= halt_q | halt;
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q     <= StIssue;
              mem_rd_en_q <= 1'b1;
              halt_q      <= 1'b0;
            end
          end
          StIssue: state_q <= StWait;
          StWait: begin
            if (lat_done) begin
              ir_out_q   <= mem_rdata;
              ir_valid_q <= 1'b1;
              state_q    <= StHold;
            end
          end
          StHold: begin
            if (ir_ready) begin
              ir_valid_q <= 1'b0;
              if (jump_req) begin
                state_q       <= StJump;
                pc_write_en_q <= 1'b1;
                pc_datain_q   <= DATA_W'(jump_target);
              end else begin
                state_q     <= StInc;
                pc_inc_en_q <= 1'b1;
              end
            end
          end
          StInc, StJump: begin
            if (halt_q) begin
              state_q <= StIdle;
            end else begin
              state_q     <= StIssue;
              mem_rd_en_q <= 1'b1;
            end
          end
          StClear: begin
            state_q     <= StIssue;
            mem_rd_en_q <= 1'b1;
            halt_q      <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (restart || ((state_q == StIdle) && start)) begin
      stall_q <= '0;
    end else if (ir_valid_q && !ir_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign pc_write_en = pc_write_en_q;
  assign pc_inc_en   = pc_inc_en_q;
  assign pc_clr_en   = pc_clr_en_q;
  assign pc_datain   = pc_datain_q;
  assign mem_rd_en   = mem_rd_en_q;
  // PC settles on the edge that enters ISSUE, so the address is taken live.
  assign mem_addr    = mem_rd_en_q ? pc_addr : '0;
  assign ir_out      = ir_out_q;
  assign ir_valid    = ir_valid_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a PC model and a two-stage instruction memory.
// Build with FETCH_STALL_CNT_EN defined to also check the stall counter.
module tb_fetch_seq;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, restart, halt;
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_write_en, pc_inc_en, pc_clr_en;
  logic [DATA_W-1:0] pc_datain;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir_out;
  logic              ir_valid, ir_ready, jump_req;
  logic [ADDR_W-1:0] jump_target;
  logic              busy;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [16];
  logic [DATA_W-1:0] rd_s0, rd_s1;
  logic [ADDR_W-1:0] pc;

  fetch_seq #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MEM_LAT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .restart     (restart),
    .halt        (halt),
    .pc_addr     (pc_addr),
    .pc_write_en (pc_write_en),
    .pc_inc_en   (pc_inc_en),
    .pc_clr_en   (pc_clr_en),
    .pc_datain   (pc_datain),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .jump_req    (jump_req),
    .jump_target (jump_target),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Program counter driven by the strobes.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (pc_clr_en) pc <= '0;
    else if (pc_write_en) pc <= pc_datain[ADDR_W-1:0];
    else if (pc_inc_en) pc <= pc + 12'd1;
  end
  assign pc_addr = pc;

  // Data valid two edges after the read strobe is sampled.
  always @(posedge clk) begin
    rd_s0 <= mem_rd_en ? mem[mem_addr[3:0]] : '0;
    rd_s1 <= rd_s0;
  end
  assign mem_rdata = rd_s1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (ir_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: ir_valid=%b after %0d cycles, required 1", name, ir_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; restart = 0; halt = 0; ir_ready = 1; jump_req = 0; jump_target = '0;
    tick(); tick();
    checks++;
    if ({pc_write_en, pc_inc_en, pc_clr_en, mem_rd_en, ir_valid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 000000",
               {pc_write_en, pc_inc_en, pc_clr_en, mem_rd_en, ir_valid, busy});
    end
    checks++;
    if ({ir_out, pc_datain, mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data: ir_out=%h pc_datain=%h mem_addr=%h required 0",
               ir_out, pc_datain, mem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 12'h000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_issue0: rd_en=%b addr=%h busy=%b required 1 000 1",
               mem_rd_en, mem_addr, busy);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (mem_rd_en !== 1'b0 || ir_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait%0d: rd_en=%b ir_valid=%b required 0 0", i, mem_rd_en, ir_valid);
      end
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_out !== 17'h0ABC) begin
      errors++;
      $display("FAIL fetch_hold: ir_valid=%b ir_out=%h required 1 0abc", ir_valid, ir_out);
    end
    tick();
    checks++;
    if (pc_inc_en !== 1'b1 || pc_write_en !== 1'b0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_inc: inc=%b wr=%b ir_valid=%b required 1 0 0",
               pc_inc_en, pc_write_en, ir_valid);
    end
    tick();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 12'h001 || pc_inc_en !== 1'b0) begin
      errors++;
      $display("FAIL fetch_issue1: rd_en=%b addr=%h inc=%b required 1 001 0",
               mem_rd_en, mem_addr, pc_inc_en);
    end
  endtask

  task automatic test_backpressure();
    ir_ready = 1'b0;
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      if (i != 0) tick();
      checks++;
      if (ir_valid !== 1'b1 || ir_out !== 17'h1111 || pc_inc_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: ir_valid=%b ir_out=%h inc=%b required 1 1111 0",
                 i, ir_valid, ir_out, pc_inc_en);
      end
    end
    tick();
`ifdef FETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL bp_stall_cnt: got %0d required 5", stall_cnt);
    end
`endif
    checks++;
    if (ir_valid !== 1'b1 || pc_inc_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_still_hold: ir_valid=%b inc=%b required 1 0", ir_valid, pc_inc_en);
    end
    ir_ready = 1'b1;
    tick();
    checks++;
    if (pc_inc_en !== 1'b1 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: inc=%b ir_valid=%b required 1 0", pc_inc_en, ir_valid);
    end
    tick();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 12'h002) begin
      errors++;
      $display("FAIL bp_issue2: rd_en=%b addr=%h required 1 002", mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_jump();
    // Raised during ISSUE/WAIT too: must be ignored until the handshake.
    jump_req = 1'b1;
    jump_target = 12'h00C;
    wait_valid("jump_valid");
    checks++;
    if (ir_out !== 17'h1222) begin
      errors++;
      $display("FAIL jump_ir: got %h required 1222", ir_out);
    end
    tick();
    checks++;
    if (pc_write_en !== 1'b1 || pc_datain !== 17'd12 || pc_inc_en !== 1'b0) begin
      errors++;
      $display("FAIL jump_load: wr=%b datain=%h inc=%b required 1 0000c 0",
               pc_write_en, pc_datain, pc_inc_en);
    end
    jump_req = 1'b0;
    jump_target = '0;
    tick();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 12'h00C || pc_inc_en !== 1'b0 || pc_write_en !== 1'b0)
    begin
      errors++;
      $display("FAIL jump_issue: rd_en=%b addr=%h inc=%b wr=%b required 1 00c 0 0",
               mem_rd_en, mem_addr, pc_inc_en, pc_write_en);
    end
  endtask

  task automatic test_restart_wait();
    int n = 0;
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (pc_clr_en !== 1'b1 || ir_valid !== 1'b0 || mem_rd_en !== 1'b0 || pc_inc_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_clear: clr=%b ir_valid=%b rd_en=%b inc=%b required 1 0 0 0",
               pc_clr_en, ir_valid, mem_rd_en, pc_inc_en);
    end
    tick();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 12'h000) begin
      errors++;
      $display("FAIL rst_issue0: rd_en=%b addr=%h required 1 000", mem_rd_en, mem_addr);
    end
    ir_ready = 1'b0;
    while (ir_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
      checks++;
      if (ir_out === 17'h0C0C) begin
        errors++;
        $display("FAIL rst_discard: ir_out=%h from discarded read, required anything else", ir_out);
      end
    end
    checks++;
    if (ir_valid !== 1'b1 || ir_out !== 17'h0ABC || n != 3) begin
      errors++;
      $display("FAIL rst_refetch: ir_valid=%b ir_out=%h cycles=%0d required 1 0abc 3",
               ir_valid, ir_out, n);
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++;
    if (ir_valid !== 1'b1 || pc_inc_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL halt_hold: ir_valid=%b inc=%b busy=%b required 1 0 1", ir_valid, pc_inc_en, busy);
    end
    ir_ready = 1'b1;
    tick();
    checks++;
    if (pc_inc_en !== 1'b1 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_inc: inc=%b ir_valid=%b required 1 0", pc_inc_en, ir_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0 || pc_inc_en !== 1'b0) begin
        errors++;
        $display("FAIL halt_idle%0d: busy=%b rd_en=%b inc=%b required 0 0 0",
                 i, busy, mem_rd_en, pc_inc_en);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 12'h001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL halt_resume: rd_en=%b addr=%h busy=%b required 1 001 1",
               mem_rd_en, mem_addr, busy);
    end
  endtask

  task automatic test_async_reset();
    ir_ready = 1'b0;
    wait_valid("arst_valid");
    checks++;
    if (ir_out !== 17'h1111) begin
      errors++;
      $display("FAIL arst_ir: got %h required 1111", ir_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({pc_write_en, pc_inc_en, pc_clr_en, mem_rd_en, ir_valid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL arst_strobes: got %b required 000000",
               {pc_write_en, pc_inc_en, pc_clr_en, mem_rd_en, ir_valid, busy});
    end
    checks++;
    if ({ir_out, pc_datain, mem_addr} !== '0) begin
      errors++;
      $display("FAIL arst_data: ir_out=%h pc_datain=%h mem_addr=%h required 0",
               ir_out, pc_datain, mem_addr);
    end
`ifdef FETCH_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL arst_stall_cnt: got %0d required 0", stall_cnt);
    end
`endif
    tick();
    rst = 1'b0;
    ir_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    start = 1'b1;
    restart = 1'b1;
    tick();
    start = 1'b0;
    restart = 1'b0;
    checks++;
    if (pc_clr_en !== 1'b1 || mem_rd_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_clear: clr=%b rd_en=%b busy=%b required 1 0 1", pc_clr_en, mem_rd_en, busy);
    end
    tick();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 12'h000) begin
      errors++;
      $display("FAIL b2b_issue0: rd_en=%b addr=%h required 1 000", mem_rd_en, mem_addr);
    end
    for (int k = 1; k <= 2; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (mem_rd_en !== 1'b1 && n < 20);
      checks++;
      if (n != 5 || mem_addr !== 12'(k)) begin
        errors++;
        $display("FAIL b2b_period%0d: cycles=%0d addr=%h required 5 %h", k, n, mem_addr, 12'(k));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 17'(32'h1000 + i * 32'h111);
    mem[0]  = 17'h0ABC;
    mem[1]  = 17'h1111;
    mem[2]  = 17'h1222;
    mem[12] = 17'h0C0C;
    test_reset();
    test_fetch();
    test_backpressure();
    test_jump();
    test_restart_wait();
    test_halt();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Fetch sequencer that acts as the initiator driving the program counter's control interface (write_en / inc_en / clr_en / datain).
- Reads instruction memory at the PC's current address, waits a fixed memory latency, and holds the word in an instruction register.
- Presents the instruction to the decoder with a valid/ready handshake, then increments the PC or loads a jump target.

Parameters:
- ADDR_W, 12, PC address width; matches the PC's dataout.
- DATA_W, 17, instruction width; also the width of the PC's datain.
- MEM_LAT, 2, cycles from the mem_rd_en edge to mem_rdata valid; legal range 1..7.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins fetching from the current PC; honoured only in IDLE.
- restart  in  1  one-cycle pulse; clears the PC to 0 and restarts fetch; honoured in any state.
- halt  in  1  request to stop; sticky until the next start or restart.
- pc_addr  in  ADDR_W  current PC value.
- pc_write_en  out  1  PC load strobe.
- pc_inc_en  out  1  PC increment strobe.
- pc_clr_en  out  1  PC clear strobe.
- pc_datain  out  DATA_W  PC load value.
- mem_rd_en  out  1  instruction memory read strobe.
- mem_addr  out  ADDR_W  instruction memory address.
- mem_rdata  in  DATA_W  instruction memory read data.
- ir_out  out  DATA_W  instruction register.
- ir_valid  out  1  ir_out holds an unconsumed instruction.
- ir_ready  in  1  decoder accepts ir_out.
- jump_req  in  1  qualified with the ir_valid & ir_ready handshake; load the PC instead of incrementing.
- jump_target  in  ADDR_W  jump address.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs are 0, including ir_out, pc_datain, mem_addr and the halt flag.
- Strobe rule: at most one of pc_write_en / pc_inc_en / pc_clr_en is high in any cycle. Each is a one-cycle registered pulse.
- States:
  - IDLE: all strobes 0. start → ISSUE. start also clears the halt flag.
  - ISSUE: mem_rd_en=1 and mem_addr=pc_addr for exactly one cycle; load the latency counter with MEM_LAT → WAIT.
  - WAIT: decrement the counter each cycle. On the edge where mem_rdata is valid (MEM_LAT edges after the ISSUE edge), set ir_out←mem_rdata and ir_valid←1 → HOLD.
  - HOLD: ir_valid=1 and ir_out stable until ir_valid & ir_ready.
    - On the handshake with jump_req=0 → INC.
    - On the handshake with jump_req=1 → JUMP, capturing jump_target. The target is zero-extended to DATA_W for pc_datain.
    - ir_valid drops on the handshake edge.
  - INC: pc_inc_en=1 for one cycle → ISSUE, or → IDLE if the halt flag is set.
  - JUMP: pc_write_en=1 and pc_datain=target for one cycle → ISSUE, or → IDLE if the halt flag is set.
  - CLEAR: pc_clr_en=1 for one cycle; the halt flag is cleared → ISSUE.
- Per-instruction latency from ISSUE to ir_valid is MEM_LAT+1 cycles. Minimum instruction period is MEM_LAT+3 cycles when ir_ready is held high.
- PC timing: the PC updates on the INC/JUMP/CLEAR edge, so ISSUE always samples the updated pc_addr.
- restart from any state, including WAIT and HOLD:
  - Goes to CLEAR next cycle; ir_valid←0.
  - Any in-flight read is discarded: the counter resets and mem_rdata is not captured.
- restart and start in the same cycle: restart wins.
- halt asserted during HOLD does not drop ir_valid. The current instruction completes its INC/JUMP, then the block goes to IDLE. halt in IDLE only sets the flag.
- jump_req without a handshake is ignored.
- pc_addr wrap at 2^ADDR_W-1 is the PC's responsibility; no special handling here.
- rst asserted mid-operation: immediate return to reset values with no pending strobes.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined: adds port stall_cnt, out, 16 bits.
  - Increments every cycle with ir_valid=1 and ir_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst, restart, and start-from-IDLE.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - State enum {IDLE, ISSUE, WAIT, HOLD, INC, JUMP, CLEAR}.
  - Default ADDR_W/DATA_W constants.
  - 3-bit MEM_LAT counter width constant.
- Sub-module: fetch_lat_cnt.
  - Loadable down-counter with a done flag, used for WAIT.
  - Reused by any later multi-cycle memory client.

Test Plan:
- Reset, start, MEM_LAT=2, memory[0]=17'h0ABC, ir_ready=1:
  - mem_rd_en at addr 0 one cycle after start.
  - ir_valid with ir_out=17'h0ABC 3 cycles after ISSUE.
  - pc_inc_en pulse follows, then ISSUE at addr 1.
- Backpressure: ir_ready=0 for 5 cycles in HOLD:
  - ir_out is stable and pc_inc_en stays low throughout.
  - With FETCH_STALL_CNT_EN, stall_cnt=5.
- Jump: handshake with jump_req=1 and jump_target=12'h00C:
  - One pc_write_en pulse with pc_datain=17'd12 and no pc_inc_en.
  - Next ISSUE mem_addr=12.
- Restart during WAIT:
  - pc_clr_en pulse; old mem_rdata never appears on ir_out.
  - Next ISSUE mem_addr=0.
- halt during HOLD, then handshake:
  - INC completes, state returns to IDLE, busy=0, no further mem_rd_en.
  - A new start resumes fetching at the incremented address.
- Async rst asserted mid-HOLD without a clock edge: all outputs 0 immediately.
